rf_bypass_multi: RTL



---
 rtl/rf_bypass_multi_pkg.sv | 21 ++
 rtl/rf_bank.sv | 61 ++++++
 rtl/rf_bypass_multi.sv | 86 ++++++++
 3 files changed

// File: rtl/rf_bypass_multi_pkg.sv
// Shared defaults and slicing helpers for the bypassed multi-port register file.
// Flattened port vectors place port k at [k*W +: W].
package rf_bypass_multi_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_SELW   = 3;
  localparam int DEF_NREAD  = 2;
  localparam int DEF_NWRITE = 1;

  localparam int ZERO_REG_OFF = 0;
  localparam int ZERO_REG_ON  = 1;

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

  function automatic bit zero_reg_enabled(input int zero_reg);
    return zero_reg == ZERO_REG_ON;
  endfunction

endpackage

// File: rtl/rf_bank.sv
// Register storage with synchronous clear and highest-port-wins write resolution.
// Exposes the raw stored value selected by each read port (no bypass).
module rf_bank
  import rf_bypass_multi_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SELW     = DEF_SELW,
  parameter int NREAD    = DEF_NREAD,
  parameter int NWRITE   = DEF_NWRITE,
  parameter int ZERO_REG = ZERO_REG_OFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*SELW-1:0]   readregsel,
  input  logic [NWRITE*SELW-1:0]  writeregsel,
  input  logic [NWRITE*WIDTH-1:0] writedata,
  input  logic [NWRITE-1:0]       write,
  output logic [NREAD*WIDTH-1:0]  storeddata
);

  localparam int NREGS = 2 ** SELW;

  logic [WIDTH-1:0] regs [NREGS];

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] q;

    // Ascending scan: the last matching port, i.e. the highest index, wins.
    always_comb begin
      load      = 1'b0;
      load_data = q;
      for (int j = 0; j < NWRITE; j++) begin
        if (write[j] && (writeregsel[slice_lo(j, SELW) +: SELW] == SELW'(r))) begin
          load      = 1'b1;
          load_data = writedata[slice_lo(j, WIDTH) +: WIDTH];
        end
      end
      if (zero_reg_enabled(ZERO_REG) && (r == 0)) begin
        load = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (load) begin
        q <= load_data;
      end
    end

    assign regs[r] = q;
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    assign storeddata[slice_lo(k, WIDTH) +: WIDTH] =
      regs[readregsel[slice_lo(k, SELW) +: SELW]];
  end

endmodule

// File: rtl/rf_bypass_multi.sv
// Multi-ported register file with same-cycle write-to-read bypass, optional
// hardwired zero register and a combinational write-collision flag.
module rf_bypass_multi
  import rf_bypass_multi_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SELW     = DEF_SELW,
  parameter int NREAD    = DEF_NREAD,
  parameter int NWRITE   = DEF_NWRITE,
  parameter int ZERO_REG = ZERO_REG_OFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*SELW-1:0]   readregsel,
  output logic [NREAD*WIDTH-1:0]  readdata,
  input  logic [NWRITE*SELW-1:0]  writeregsel,
  input  logic [NWRITE*WIDTH-1:0] writedata,
  input  logic [NWRITE-1:0]       write,
  output logic                    err
);

  logic [NREAD*WIDTH-1:0] storeddata;
  logic [NWRITE-1:0]      dup;

  rf_bank #(
    .WIDTH    (WIDTH),
    .SELW     (SELW),
    .NREAD    (NREAD),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .readregsel  (readregsel),
    .writeregsel (writeregsel),
    .writedata   (writedata),
    .write       (write),
    .storeddata  (storeddata)
  );

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] rd;

    assign sel = readregsel[slice_lo(k, SELW) +: SELW];

    // Later overrides take precedence: reset, then zero register, then bypass.
    always_comb begin
      rd = storeddata[slice_lo(k, WIDTH) +: WIDTH];
      for (int j = 0; j < NWRITE; j++) begin
        if (write[j] && (writeregsel[slice_lo(j, SELW) +: SELW] == sel)) begin
          rd = writedata[slice_lo(j, WIDTH) +: WIDTH];
        end
      end
      if (zero_reg_enabled(ZERO_REG) && (sel == '0)) begin
        rd = '0;
      end
      if (rst) begin
        rd = '0;
      end
    end

    assign readdata[slice_lo(k, WIDTH) +: WIDTH] = rd;
  end

  // Each port flags a match against any higher-indexed enabled port; register 0
  // still counts even when it is hardwired to zero.
  for (genvar a = 0; a < NWRITE; a++) begin : g_coll
    logic hit;

    always_comb begin
      hit = 1'b0;
      for (int b = a + 1; b < NWRITE; b++) begin
        if (write[a] && write[b] &&
            (writeregsel[slice_lo(a, SELW) +: SELW] == writeregsel[slice_lo(b, SELW) +: SELW])) begin
          hit = 1'b1;
        end
      end
    end

    assign dup[a] = hit;
  end

  assign err = (|dup) & ~rst;

endmodule
